// File: rtl/ovl_win_change_mc_if.sv
// Bus-level interface for the multi-channel window-change checker.
// master: drives enable/start_event/end_event/test_expr and observes the status outputs.
// slave : the checker itself.
interface ovl_win_change_mc_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 8
);
    logic                      enable;
    logic [CHANNELS-1:0]       start_event;
    logic [CHANNELS-1:0]       end_event;
    logic [WIDTH*CHANNELS-1:0] test_expr;
    logic [CHANNELS-1:0]       window_open;
    logic [CNT_W*CHANNELS-1:0] change_count;
    logic [CHANNELS-1:0]       fire_min;
    logic [CHANNELS-1:0]       fire_max;
    logic [CHANNELS-1:0]       fire_timeout;

    modport master (
        output enable, start_event, end_event, test_expr,
        input  window_open, change_count, fire_min, fire_max, fire_timeout
    );

    modport slave (
        input  enable, start_event, end_event, test_expr,
        output window_open, change_count, fire_min, fire_max, fire_timeout
    );
endinterface

// File: rtl/ovl_win_change_mc.sv
// Multi-channel window-change checker. Each channel opens a window on start_event,
// counts cycle-to-cycle changes of its test_expr slice, and on end_event checks the
// count against [MIN_CHANGES, MAX_CHANGES]. Optional window timeout.
// Ports:
//   clock        - sampling clock, posedge
//   reset        - synchronous, active-high
//   bus (slave)  - enable, start_event, end_event, test_expr in;
//                  window_open, change_count, fire_min, fire_max, fire_timeout out
module ovl_win_change_mc #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned MIN_CHANGES = 1,
    parameter int unsigned MAX_CHANGES = 0,
    parameter int unsigned MAX_WINDOW  = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    ovl_win_change_mc_if.slave      bus
);

    typedef enum logic {IDLE = 1'b0, WINDOW = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(MAX_WINDOW - 1);

    state_t             state_q  [CHANNELS];
    state_t             state_d  [CHANNELS];
    logic [WIDTH-1:0]   prev_q   [CHANNELS];
    logic [WIDTH-1:0]   prev_d   [CHANNELS];
    logic [CNT_W-1:0]   cnt_q    [CHANNELS];
    logic [CNT_W-1:0]   cnt_d    [CNT_W > 0 ? CHANNELS : 1];
    logic [CNT_W-1:0]   wcnt_q   [CHANNELS];
    logic [CNT_W-1:0]   wcnt_d   [CHANNELS];
    logic [CNT_W-1:0]   cnt_inc  [CHANNELS];
    logic [CNT_W-1:0]   wcnt_inc [CHANNELS];
    logic [CHANNELS-1:0] fmin_q, fmin_d;
    logic [CHANNELS-1:0] fmax_q, fmax_d;
    logic [CHANNELS-1:0] fto_q,  fto_d;

    // Saturating increments of the change and window counters.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_inc[c]  = cnt_q[c];
            wcnt_inc[c] = wcnt_q[c];
            if ((bus.test_expr[c*WIDTH +: WIDTH] != prev_q[c]) && (cnt_q[c] != CNT_MAX))
                cnt_inc[c] = cnt_q[c] + CNT_W'(1);
            if (wcnt_q[c] != CNT_MAX)
                wcnt_inc[c] = wcnt_q[c] + CNT_W'(1);
        end
    end

    // Next-state and fire logic; everything holds and fires drop while disabled.
    always_comb begin
        fmin_d = '0;
        fmax_d = '0;
        fto_d  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            prev_d[c]  = prev_q[c];
            cnt_d[c]   = cnt_q[c];
            wcnt_d[c]  = wcnt_q[c];
            if (bus.enable) begin
                prev_d[c] = bus.test_expr[c*WIDTH +: WIDTH];
                case (state_q[c])
                    IDLE: begin
                        if (bus.start_event[c]) begin
                            state_d[c] = WINDOW;
                            cnt_d[c]   = '0;
                            wcnt_d[c]  = '0;
                        end
                    end
                    WINDOW: begin
                        cnt_d[c]  = cnt_inc[c];
                        wcnt_d[c] = wcnt_inc[c];
                        // end_event takes priority over a timeout on the same cycle
                        if (bus.end_event[c]) begin
                            state_d[c] = IDLE;
                            fmin_d[c]  = (MIN_CHANGES != 0) && (32'(cnt_inc[c]) < MIN_CHANGES);
                            fmax_d[c]  = (MAX_CHANGES != 0) && (32'(cnt_inc[c]) > MAX_CHANGES);
                        end else if ((MAX_WINDOW != 0) && (wcnt_q[c] == WIN_LAST)) begin
                            state_d[c] = IDLE;
                            fto_d[c]   = 1'b1;
                        end
                    end
                    default: state_d[c] = IDLE;
                endcase
            end
        end
    end

    // State and status registers; reset loads prev with the live sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                prev_q[c]  <= bus.test_expr[c*WIDTH +: WIDTH];
                cnt_q[c]   <= '0;
                wcnt_q[c]  <= '0;
            end
            fmin_q <= '0;
            fmax_q <= '0;
            fto_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                prev_q[c]  <= prev_d[c];
                cnt_q[c]   <= cnt_d[c];
                wcnt_q[c]  <= wcnt_d[c];
            end
            fmin_q <= fmin_d;
            fmax_q <= fmax_d;
            fto_q  <= fto_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign bus.window_open[g]                  = (state_q[g] == WINDOW);
        assign bus.change_count[g*CNT_W +: CNT_W]  = cnt_q[g];
    end

    assign bus.fire_min     = fmin_q;
    assign bus.fire_max     = fmax_q;
    assign bus.fire_timeout = fto_q;

endmodule

// File: tb/tb_ovl_win_change_mc.sv
// Scoreboard bench for ovl_win_change_mc (WIDTH=4, CHANNELS=2, MIN=1, MAX=2, MAX_WINDOW=5).
module tb_ovl_win_change_mc;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CH    = 2;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             fmin;
        logic             fmax;
        logic             fto;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [CH-1:0] prev_wo = '0;

    always #5 clk = ~clk;

    ovl_win_change_mc_if #(.WIDTH(WIDTH), .CHANNELS(CH), .CNT_W(CNT_W)) bus ();

    ovl_win_change_mc #(
        .WIDTH(WIDTH), .CHANNELS(CH), .MIN_CHANGES(1), .MAX_CHANGES(2),
        .MAX_WINDOW(5), .CNT_W(CNT_W)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic fmin, input logic fmax, input logic fto, input int cnt);
        exp_t e;
        e.fmin = fmin;
        e.fmax = fmax;
        e.fto  = fto;
        e.cnt  = CNT_W'(cnt);
        return e;
    endfunction

    // Monitor: a channel presents a result whenever it fires or its window closes.
    always @(negedge clk) begin
        if (rst) begin
            prev_wo = '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if ((prev_wo[c] && !bus.window_open[c]) || bus.fire_min[c] ||
                    bus.fire_max[c] || bus.fire_timeout[c]) begin
                    exp_t got;
                    exp_t e;
                    got.fmin = bus.fire_min[c];
                    got.fmax = bus.fire_max[c];
                    got.fto  = bus.fire_timeout[c];
                    got.cnt  = bus.change_count[c*CNT_W +: CNT_W];
                    checks++;
                    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                        errors++;
                        $display("FAIL unexpected_event ch%0d: got min=%0b max=%0b to=%0b cnt=%0d expected none",
                                 c, got.fmin, got.fmax, got.fto, got.cnt);
                    end else begin
                        e = (c == 0) ? q0.pop_front() : q1.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL result ch%0d: got min=%0b max=%0b to=%0b cnt=%0d expected min=%0b max=%0b to=%0b cnt=%0d",
                                     c, got.fmin, got.fmax, got.fto, got.cnt, e.fmin, e.fmax, e.fto, e.cnt);
                        end
                    end
                end
            end
            prev_wo = bus.window_open;
        end
    end

    initial begin
        bus.enable      = 1'b1;
        bus.start_event = '0;
        bus.end_event   = '0;
        bus.test_expr   = 8'h35;

        // Reset with data toggling
        rst = 1'b1;
        step();
        bus.test_expr = 8'h5A;
        step();
        check("reset_window_open", 32'(bus.window_open), 32'h0);
        check("reset_change_count", 32'(bus.change_count), 32'h0);
        check("reset_fire_min", 32'(bus.fire_min), 32'h0);
        check("reset_fire_max", 32'(bus.fire_max), 32'h0);
        check("reset_fire_timeout", 32'(bus.fire_timeout), 32'h0);
        rst = 1'b0;
        bus.test_expr = 8'h30;
        step();

        // No change inside window -> fire_min, count 0; second end cycle ignored
        bus.test_expr[3:0] = 4'b1000; step();
        bus.test_expr[3:0] = 4'b0100; step();
        bus.start_event[0] = 1'b1; step();
        bus.start_event[0] = 1'b0; step();
        q0.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        bus.end_event[0] = 1'b1; step();
        step();
        bus.end_event[0] = 1'b0; step();

        // Three changes -> fire_max, count 3
        bus.start_event[0] = 1'b1; step();
        bus.start_event[0] = 1'b0;
        bus.test_expr[3:0] = 4'b0101; step();
        bus.test_expr[3:0] = 4'b0110; step();
        q0.push_back(mk(1'b0, 1'b1, 1'b0, 3));
        bus.test_expr[3:0] = 4'b0111;
        bus.end_event[0] = 1'b1; step();
        bus.end_event[0] = 1'b0; step();
        step();
        check("idle_holds_count", 32'(bus.change_count[7:0]), 32'd3);
        check("idle_window_closed", 32'(bus.window_open), 32'h0);

        // Change sampled on the end cycle counts -> count 1, no fire
        bus.start_event[0] = 1'b1; step();
        bus.start_event[0] = 1'b0;
        check("open_rises", 32'(bus.window_open), 32'h1);
        check("open_clears_count", 32'(bus.change_count[7:0]), 32'd0);
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 1));
        bus.test_expr[3:0] = 4'b1111;
        bus.end_event[0] = 1'b1; step();
        bus.end_event[0] = 1'b0; step();

        // Timeout after 5 window cycles, later end ignored
        bus.start_event[0] = 1'b1; step();
        bus.start_event[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        q0.push_back(mk(1'b0, 1'b0, 1'b1, 0));
        step();
        bus.end_event[0] = 1'b1; step();
        bus.end_event[0] = 1'b0; step();

        // end_event on the exact timeout cycle wins -> normal evaluation
        bus.start_event[0] = 1'b1; step();
        bus.start_event[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        q0.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        bus.end_event[0] = 1'b1; step();
        bus.end_event[0] = 1'b0; step();

        // Two channels, enable dropped mid-window while ch0 toggles
        bus.test_expr = 8'h30;
        step();
        bus.start_event = 2'b11; step();
        bus.start_event = 2'b00;
        bus.test_expr[3:0] = 4'b0001; step();
        bus.enable = 1'b0;
        bus.test_expr[3:0] = 4'b0010; step();
        bus.test_expr[3:0] = 4'b0011; step();
        bus.test_expr[3:0] = 4'b0100; step();
        check("disabled_window_frozen", 32'(bus.window_open), 32'h3);
        check("disabled_count_frozen", 32'(bus.change_count[7:0]), 32'd1);
        bus.enable = 1'b1;
        bus.test_expr[3:0] = 4'b0001; step();
        q0.push_back(mk(1'b0, 1'b0, 1'b0, 2));
        q1.push_back(mk(1'b1, 1'b0, 1'b0, 0));
        bus.test_expr[3:0] = 4'b0011;
        bus.end_event = 2'b11; step();
        bus.end_event = 2'b00; step();
        check("multi_ch1_count", 32'(bus.change_count[15:8]), 32'd0);

        // Reset mid-window discards the window without firing
        bus.start_event[1] = 1'b1; step();
        bus.start_event[1] = 1'b0;
        bus.test_expr[7:4] = 4'b1100; step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        check("midreset_window_open", 32'(bus.window_open), 32'h0);
        check("midreset_count", 32'(bus.change_count[15:8]), 32'd0);
        bus.end_event[1] = 1'b1; step();
        bus.end_event[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();

        check("queue0_drained", 32'(q0.size()), 32'd0);
        check("queue1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovl_win_change_mc.md
Name: ovl_win_change_mc

Overview:
- Multi-channel, parametrised successor to the single-channel window-change checker in the OVL checker library.
- Each channel opens a window on its own start_event and closes it on its own end_event.
- While the window is open, the channel counts cycle-to-cycle changes of its test_expr slice. At window close it checks the count against [MIN_CHANGES, MAX_CHANGES].
- Adds a window timeout and per-channel status outputs. Used in ivl_uvm OVL regressions as a drop-in bus-level window checker.

Parameters:
- WIDTH, 4, bit width of each channel's test_expr slice.
- CHANNELS, 2, number of independent checker channels.
- MIN_CHANGES, 1, minimum changes required inside a window (0 disables the low check).
- MAX_CHANGES, 0, maximum changes allowed inside a window (0 = unlimited).
- MAX_WINDOW, 0, window length limit in enabled cycles (0 = no timeout).
- CNT_W, 8, width of the per-channel change and window counters; both saturate at all-ones.

Ports:
- clock  input  1  sampling clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global enable; when low, all channels are frozen.
- start_event  input  CHANNELS  per-channel window-open request.
- end_event  input  CHANNELS  per-channel window-close request.
- test_expr  input  WIDTH*CHANNELS  channel c occupies bits [c*WIDTH +: WIDTH].
- window_open  output  CHANNELS  1 while channel is in WINDOW.
- change_count  output  CNT_W*CHANNELS  live change count per channel; cleared on window open.
- fire_min  output  CHANNELS  1-cycle pulse: window closed with count < MIN_CHANGES.
- fire_max  output  CHANNELS  1-cycle pulse: window closed with count > MAX_CHANGES.
- fire_timeout  output  CHANNELS  1-cycle pulse: window reached MAX_WINDOW cycles without end_event.

Behaviour:
- Reset (sync, active-high) on the clock edge where reset=1:
  - all channels go to IDLE;
  - all outputs go to 0;
  - counters clear;
  - each prev-sample register is loaded with the current test_expr slice.
- Per-channel FSM, evaluated only when enable=1. Each prev-sample register updates every enabled cycle.
- IDLE:
  - start_event[c]=1: go to WINDOW, clear change_count and the window counter, latch prev = test_expr slice.
  - end_event[c] is ignored in IDLE, including when it coincides with start_event; the window still opens.
- WINDOW, on each enabled cycle:
  - If slice != prev, change_count increments, saturating at 2^CNT_W-1. This includes the cycle where end_event is sampled.
  - The window counter increments, saturating.
- WINDOW with end_event[c]=1:
  - Evaluate final count = count plus this cycle's change, then return to IDLE.
  - If MIN_CHANGES>0 and final count < MIN_CHANGES, fire_min[c] pulses high for 1 cycle, starting the cycle after the end sample.
  - If MAX_CHANGES>0 and final count > MAX_CHANGES, fire_max[c] pulses high for 1 cycle, starting the cycle after the end sample.
- start_event[c] while in WINDOW is ignored; there is no restart.
- end_event and start_event in the same WINDOW cycle: the window closes and evaluates; it does not reopen. start must be re-asserted in IDLE.
- Timeout (MAX_WINDOW>0): if the window counter equals MAX_WINDOW-1 and end_event=0 this cycle, fire_timeout[c] pulses next cycle and the channel returns to IDLE. No min/max evaluation is done for that window.
- end_event on the exact timeout cycle: end wins, normal evaluation, no fire_timeout.
- window_open[c] is registered and rises the cycle after start is accepted. It falls in the same cycle the fire pulses appear.
- change_count holds its last value in IDLE until the next window opens.
- enable=0:
  - FSM, counters and prev-samples are frozen; fire outputs are forced to 0.
  - On re-enable, the first compare is against the frozen prev sample.
- Reset asserted mid-window: the window is discarded, no fire.
- Channels are fully independent: no cross-channel state, and simultaneous fires on several channels are allowed.
- All fire outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: reset=1 for 1 clk with data toggling -> all fire=0, window_open=0, change_count=0.
- No change in window (W=4, CH=1, MIN=1): data=4'b1000→4'b0100 before start; start 1 clk; hold 4'b0100; end 2 clks -> fire_min[0] pulse of 1 cycle after the first end sample, count=0.
- Change counted at end cycle: start, data changes exactly on the end_event sample cycle -> count=1, no fire_min.
- Upper bound (MAX=2): 3 changes inside window -> fire_max pulse, change_count=3, fire_min=0.
- Timeout (MAX_WINDOW=5): start, no end for 6 clks -> fire_timeout on cycle 5, window_open drops; later end_event ignored.
- Multi-channel/enable (CH=2): ch0 window with 2 changes, ch1 window with none, enable=0 for 3 clks mid-window with ch0 toggling -> toggles not counted; ch1 fire_min only; ch0 silent.
